// File: rtl/car_parking_system.sv
// Car park entrance gate controller.
//
// Detects an arriving car, waits WAIT_CYCLES clocks, then samples a two-digit
// password. A correct password grants entry (green, "GO"). A wrong one refuses
// entry (red, "EE") until the correct password is presented. Both LEDs and both
// 7-segment digits are registered from the current state, so they lag the state
// by one clock.
//
// Optional build macro: PASS_TIMEOUT_EN. When it is defined, WRONG_PASS and STOP
// fall back to IDLE after TIMEOUT_CYCLES consecutive cycles without a correct
// password.
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-high reset
//   sensor_entrance in   car present at entrance
//   sensor_exit     in   car present at exit
//   password_1      in   first password digit  [1:0]
//   password_2      in   second password digit [1:0]
//   GREEN_LED       out  entry-granted indicator
//   RED_LED         out  wait/refusal indicator
//   HEX_1           out  left digit, active-low {g,f,e,d,c,b,a}
//   HEX_2           out  right digit, active-low {g,f,e,d,c,b,a}
module car_parking_system #(
  parameter int unsigned WAIT_CYCLES    = 4,
  parameter logic [1:0]  PASS_1         = 2'b01,
  parameter logic [1:0]  PASS_2         = 2'b10,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic [1:0] password_1,
  input  logic [1:0] password_2,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  // Segment patterns, active low {g,f,e,d,c,b,a}.
  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegE     = 7'h06;
  localparam logic [6:0] SegN     = 7'h2B;
  localparam logic [6:0] SegG     = 7'h02;
  localparam logic [6:0] SegO     = 7'h40;
  localparam logic [6:0] SegS     = 7'h12;
  localparam logic [6:0] SegP     = 7'h0C;

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitPassword,
    StWrongPass,
    StRightPass,
    StStop
  } state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic pass_ok;

  logic       green_q, green_d;
  logic       red_q, red_d;
  logic [6:0] hex_1_q, hex_1_d;
  logic [6:0] hex_2_q, hex_2_d;

  assign pass_ok = (password_1 == PASS_1) && (password_2 == PASS_2);

`ifdef PASS_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_expired;

  // Counts consecutive refused cycles; any exit from WRONG_PASS/STOP clears it.
  always_comb begin
    tmo_cnt_d   = '0;
    tmo_expired = 1'b0;
    if ((state_q == StWrongPass || state_q == StStop) && !pass_ok) begin
      if (tmo_cnt_q == TmoLast) begin
        tmo_expired = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic tmo_expired;
  logic unused_timeout;

  assign tmo_expired    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state logic. The wait counter only advances while the FSM stays in
  // WAIT_PASSWORD, so it is zero on every fresh entry.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      StIdle: begin
        if (sensor_entrance) state_d = StWaitPassword;
      end
      StWaitPassword: begin
        if (wait_cnt_q == WaitLast) begin
          state_d = pass_ok ? StRightPass : StWrongPass;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StWrongPass, StStop: begin
        // A correct password on the expiry cycle still wins.
        if (pass_ok) begin
          state_d = StRightPass;
        end else if (tmo_expired) begin
          state_d = StIdle;
        end
      end
      StRightPass: begin
        if (sensor_entrance && sensor_exit) begin
          state_d = StStop;
        end else if (sensor_exit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output values are derived from the current state and loaded on the next
  // edge; toggling LEDs invert their own registered value.
  always_comb begin
    green_d = 1'b0;
    red_d   = 1'b0;
    hex_1_d = SegBlank;
    hex_2_d = SegBlank;
    case (state_q)
      StWaitPassword: begin
        red_d   = 1'b1;
        hex_1_d = SegE;
        hex_2_d = SegN;
      end
      StWrongPass: begin
        red_d   = ~red_q;
        hex_1_d = SegE;
        hex_2_d = SegE;
      end
      StRightPass: begin
        green_d = ~green_q;
        hex_1_d = SegG;
        hex_2_d = SegO;
      end
      StStop: begin
        red_d   = ~red_q;
        hex_1_d = SegS;
        hex_2_d = SegP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      green_q    <= 1'b0;
      red_q      <= 1'b0;
      hex_1_q    <= SegBlank;
      hex_2_q    <= SegBlank;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      green_q    <= green_d;
      red_q      <= red_d;
      hex_1_q    <= hex_1_d;
      hex_2_q    <= hex_2_d;
    end
  end

  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign HEX_1     = hex_1_q;
  assign HEX_2     = hex_2_q;

endmodule

// File: tb/tb_car_parking_system.sv
// Self-checking bench for car_parking_system: directed scenarios followed by
// random sensor/password/reset traffic, compared cycle by cycle against a
// mode + time-in-mode reference model.
module tb_car_parking_system;

  localparam int WaitCycles    = 4;
  localparam int TimeoutCycles = 16;

  localparam int MIdle  = 0;
  localparam int MWait  = 1;
  localparam int MWrong = 2;
  localparam int MRight = 3;
  localparam int MStop  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       green_led;
  logic       red_led;
  logic [6:0] hex_1;
  logic [6:0] hex_2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int         m_mode  = MIdle;
  int         m_dwell = 0;
  logic       m_green = 1'b0;
  logic       m_red   = 1'b0;
  logic [6:0] m_hex1  = 7'h7F;
  logic [6:0] m_hex2  = 7'h7F;

  logic [6:0] hex1_tab [5] = '{7'h7F, 7'h06, 7'h06, 7'h02, 7'h12};
  logic [6:0] hex2_tab [5] = '{7'h7F, 7'h2B, 7'h06, 7'h40, 7'h0C};

  always #5 clk = ~clk;

  car_parking_system #(
    .WAIT_CYCLES   (WaitCycles),
    .PASS_1        (2'b01),
    .PASS_2        (2'b10),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sensor_entrance(sensor_entrance),
    .sensor_exit    (sensor_exit),
    .password_1     (password_1),
    .password_2     (password_2),
    .GREEN_LED      (green_led),
    .RED_LED        (red_led),
    .HEX_1          (hex_1),
    .HEX_2          (hex_2)
  );

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs held across it.
  task automatic model_update(input bit rst, input bit ent, input bit ext,
                              input logic [1:0] p1, input logic [1:0] p2);
    int nxt;
    bit ok;
    if (rst) begin
      m_mode  = MIdle;
      m_dwell = 0;
      m_green = 1'b0;
      m_red   = 1'b0;
      m_hex1  = 7'h7F;
      m_hex2  = 7'h7F;
      return;
    end
    // Displayed values follow the mode that was current before this edge.
    m_hex1  = hex1_tab[m_mode];
    m_hex2  = hex2_tab[m_mode];
    m_green = (m_mode == MRight) ? ~m_green : 1'b0;
    if (m_mode == MWait) m_red = 1'b1;
    else if (m_mode == MWrong || m_mode == MStop) m_red = ~m_red;
    else m_red = 1'b0;

    ok  = (p1 == 2'd1) && (p2 == 2'd2);
    nxt = m_mode;
    case (m_mode)
      MIdle:  if (ent) nxt = MWait;
      MWait:  if (m_dwell + 1 == WaitCycles) nxt = ok ? MRight : MWrong;
      MWrong, MStop: begin
        if (ok) nxt = MRight;
`ifdef PASS_TIMEOUT_EN
        else if (m_dwell + 1 == TimeoutCycles) nxt = MIdle;
`endif
      end
      MRight: begin
        if (ent && ext) nxt = MStop;
        else if (ext) nxt = MIdle;
      end
      default: ;
    endcase
    m_dwell = (nxt == m_mode) ? m_dwell + 1 : 0;
    m_mode  = nxt;
  endtask

  task automatic step(input bit rst, input bit ent, input bit ext,
                      input logic [1:0] p1, input logic [1:0] p2);
    reset           = rst;
    sensor_entrance = ent;
    sensor_exit     = ext;
    password_1      = p1;
    password_2      = p2;
    @(posedge clk);
    model_update(rst, ent, ext, p1, p2);
    #1;
    check_eq("green", {6'b0, green_led}, {6'b0, m_green});
    check_eq("red", {6'b0, red_led}, {6'b0, m_red});
    check_eq("hex_1", hex_1, m_hex1);
    check_eq("hex_2", hex_2, m_hex2);
  endtask

  initial begin
    // Reset held five cycles, then idle with no sensors.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // Arrival with a wrong password: WAIT_PASSWORD then WRONG_PASS.
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // Correct password recovers into RIGHT_PASS.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 2'd1, 2'd2);

    // Exit alone returns to IDLE.
    step(1'b0, 1'b0, 1'b1, 2'd1, 2'd2);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // Good password straight through, then both sensors -> STOP, then recover.
    step(1'b0, 1'b1, 1'b0, 2'd1, 2'd2);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 2'd1, 2'd2);
    step(1'b0, 1'b1, 1'b1, 2'd1, 2'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 2'd3, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 2'd1, 2'd2);
    step(1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // Reset while the wait counter is at 2, then a full fresh wait.
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b0, 1'b1, 1'b0, 2'd1, 2'd2);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 2'd1, 2'd2);
    step(1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

`ifdef PASS_TIMEOUT_EN
    // Wrong password held long enough to expire back to IDLE.
    step(1'b0, 1'b1, 1'b0, 2'd2, 2'd1);
    for (int i = 0; i < WaitCycles + TimeoutCycles + 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 2'd2, 2'd1);
    end
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit         rst;
      bit         ent;
      bit         ext;
      logic [1:0] p1;
      logic [1:0] p2;
      rst = ($urandom_range(0, 59) == 0);
      ent = ($urandom_range(0, 3) == 0);
      ext = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        p1 = 2'd1;
        p2 = 2'd2;
      end else begin
        p1 = 2'($urandom_range(0, 3));
        p2 = 2'($urandom_range(0, 3));
      end
      step(rst, ent, ext, p1, p2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
